// File: rtl/dma_peri_pkg.sv
// Shared constants for the multi-channel DMA peripheral front end.
package dma_peri_pkg;

   // Register word offsets inside one channel window
   localparam logic [3:0] REG_INT   = 4'd0;
   localparam logic [3:0] REG_LEN   = 4'd1;
   localparam logic [3:0] REG_WR_LO = 4'd2;
   localparam logic [3:0] REG_WR_HI = 4'd3;
   localparam logic [3:0] REG_RD_LO = 4'd4;
   localparam logic [3:0] REG_RD_HI = 4'd5;
   localparam logic [3:0] REG_CNT   = 4'd6;
   localparam logic [3:0] REG_START = 4'd7;
   localparam logic [3:0] REG_FEN   = 4'd8;
   localparam logic [3:0] REG_DMAC  = 4'd9;
   localparam logic [3:0] REG_SMAC  = 4'd10;
   localparam logic [3:0] REG_TYPE  = 4'd11;
   localparam logic [3:0] REG_STAT  = 4'd12;
   localparam logic [3:0] REG_MASK  = 4'd13;
   localparam logic [3:0] REG_PEND  = 4'd14;

   localparam logic [15:0] GUARD_KEY  = 16'h1234;
   localparam logic [31:0] EMPTY_WORD = 32'h8000_0000;

   // Start-guard states
   localparam logic [0:0] GS_LOCKED = 1'b0;
   localparam logic [0:0] GS_ARMED  = 1'b1;

endpackage

// File: rtl/dma_peri_chan.sv
// One DMA channel: register file, start guard, descriptor pairing, packet
// counter, sticky errors. Read data is combinational; the top registers it.
module dma_peri_chan
   import dma_peri_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int FILTER_W  = 8,
   parameter int GUARD_TMO = 1024
)(
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                rd_i,
   input  logic                wr_i,
   input  logic [3:0]          reg_i,
   input  logic [31:0]         wdata_i,
   input  logic [31:0]         dout_int_i,
   input  logic                empty_int_i,
   input  logic [15:0]         dout_len_i,
   input  logic                empty_len_i,
   input  logic                full_wr_i,
   input  logic                full_rd_i,
   input  logic                wait_free_i,
   output logic [31:0]         rdata_o,
   output logic                rden_int_o,
   output logic                rden_len_o,
   output logic                wren_wr_o,
   output logic [47:0]         din_wr_o,
   output logic                wren_rd_o,
   output logic [63:0]         din_rd_o,
   output logic                start_en_o,
   output logic                filter_en_o,
   output logic [2:0]          filter_sel_o,
   output logic [FILTER_W-1:0] filter_dmac_o,
   output logic [FILTER_W-1:0] filter_smac_o,
   output logic [FILTER_W-1:0] filter_type_o,
   output logic                pend_o
);

   localparam int TMR_W = $clog2(GUARD_TMO + 1);

   logic [0:0]          gs_q, gs_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                start_q, start_d;
   logic [31:0]         lo_wr_q, lo_wr_d, lo_rd_q, lo_rd_d;
   logic                lov_wr_q, lov_wr_d, lov_rd_q, lov_rd_d;
   logic                wren_wr_q, wren_wr_d, wren_rd_q, wren_rd_d;
   logic [47:0]         din_wr_q, din_wr_d;
   logic [63:0]         din_rd_q, din_rd_d;
   logic                pop_int_q, pop_int_d, pop_len_q, pop_len_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_seq_q, err_seq_d, err_ovf_q, err_ovf_d;
   logic [3:0]          fen_q, fen_d;
   logic [FILTER_W-1:0] dmac_q, dmac_d, smac_q, smac_d, type_q, type_d;
   logic                mask_q, mask_d;

   logic wr_hit [16];
   logic is_key;

   assign is_key = (wdata_i == {16'h0, GUARD_KEY});

   // Next-state for every channel register
   always_comb begin
      for (int r = 0; r < 16; r++) wr_hit[r] = wr_i && (reg_i == 4'(r));
      gs_d      = gs_q;
      tmr_d     = tmr_q;
      start_d   = start_q;
      lo_wr_d   = lo_wr_q;
      lo_rd_d   = lo_rd_q;
      lov_wr_d  = lov_wr_q;
      lov_rd_d  = lov_rd_q;
      wren_wr_d = 1'b0;
      wren_rd_d = 1'b0;
      din_wr_d  = din_wr_q;
      din_rd_d  = din_rd_q;
      cnt_d     = cnt_q;
      err_seq_d = err_seq_q;
      err_ovf_d = err_ovf_q;
      fen_d     = fen_q;
      dmac_d    = dmac_q;
      smac_d    = smac_q;
      type_d    = type_q;
      mask_d    = mask_q;

      // FIFO pops only when there is something to pop
      pop_int_d = rd_i && (reg_i == REG_INT) && !empty_int_i;
      pop_len_d = rd_i && (reg_i == REG_LEN) && !empty_len_i;

      // Count write-completion words; a CPU write of CNT overrides the increment
      if (pop_int_d && dout_int_i[31] && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      if (wr_hit[REG_CNT]) cnt_d = wdata_i[CNT_W-1:0];

      // Error clear first so that a set in the same cycle wins
      if (wr_hit[REG_STAT]) begin
         if (wdata_i[8]) err_seq_d = 1'b0;
         if (wdata_i[9]) err_ovf_d = 1'b0;
      end

      // Write-buffer descriptor pairing
      if (wr_hit[REG_WR_LO]) begin
         lo_wr_d  = wdata_i;
         lov_wr_d = 1'b1;
      end
      if (wr_hit[REG_WR_HI]) begin
         if (!lov_wr_q) err_seq_d = 1'b1;
         else if (full_wr_i) begin
            err_ovf_d = 1'b1;
            lov_wr_d  = 1'b0;
         end else begin
            wren_wr_d = 1'b1;
            din_wr_d  = {wdata_i[15:0], lo_wr_q};
            lov_wr_d  = 1'b0;
         end
      end

      // Read-buffer descriptor pairing
      if (wr_hit[REG_RD_LO]) begin
         lo_rd_d  = wdata_i;
         lov_rd_d = 1'b1;
      end
      if (wr_hit[REG_RD_HI]) begin
         if (!lov_rd_q) err_seq_d = 1'b1;
         else if (full_rd_i) begin
            err_ovf_d = 1'b1;
            lov_rd_d  = 1'b0;
         end else begin
            wren_rd_d = 1'b1;
            din_rd_d  = {wdata_i, lo_rd_q};
            lov_rd_d  = 1'b0;
         end
      end

      // Start guard: key arms, next START write commits, anything else relocks
      if (gs_q == GS_ARMED) begin
         tmr_d = tmr_q + 1'b1;
         if (wr_hit[REG_START]) begin
            if (is_key) tmr_d = '0;
            else begin
               start_d = wdata_i[0];
               gs_d    = GS_LOCKED;
            end
         end else if (wr_i) gs_d = GS_LOCKED;
         else if (tmr_q == TMR_W'(GUARD_TMO - 1)) gs_d = GS_LOCKED;
      end else if (wr_hit[REG_START] && is_key) begin
         gs_d  = GS_ARMED;
         tmr_d = '0;
      end

      if (wr_hit[REG_FEN])  fen_d  = wdata_i[3:0];
      if (wr_hit[REG_DMAC]) dmac_d = wdata_i[FILTER_W-1:0];
      if (wr_hit[REG_SMAC]) smac_d = wdata_i[FILTER_W-1:0];
      if (wr_hit[REG_TYPE]) type_d = wdata_i[FILTER_W-1:0];
      if (wr_hit[REG_MASK]) mask_d = wdata_i[0];
   end

   // Channel state registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         gs_q      <= GS_LOCKED;
         tmr_q     <= '0;
         start_q   <= 1'b0;
         lo_wr_q   <= '0;
         lo_rd_q   <= '0;
         lov_wr_q  <= 1'b0;
         lov_rd_q  <= 1'b0;
         wren_wr_q <= 1'b0;
         wren_rd_q <= 1'b0;
         din_wr_q  <= '0;
         din_rd_q  <= '0;
         pop_int_q <= 1'b0;
         pop_len_q <= 1'b0;
         cnt_q     <= '0;
         err_seq_q <= 1'b0;
         err_ovf_q <= 1'b0;
         fen_q     <= '0;
         dmac_q    <= '0;
         smac_q    <= '0;
         type_q    <= '0;
         mask_q    <= 1'b0;
      end else begin
         gs_q      <= gs_d;
         tmr_q     <= tmr_d;
         start_q   <= start_d;
         lo_wr_q   <= lo_wr_d;
         lo_rd_q   <= lo_rd_d;
         lov_wr_q  <= lov_wr_d;
         lov_rd_q  <= lov_rd_d;
         wren_wr_q <= wren_wr_d;
         wren_rd_q <= wren_rd_d;
         din_wr_q  <= din_wr_d;
         din_rd_q  <= din_rd_d;
         pop_int_q <= pop_int_d;
         pop_len_q <= pop_len_d;
         cnt_q     <= cnt_d;
         err_seq_q <= err_seq_d;
         err_ovf_q <= err_ovf_d;
         fen_q     <= fen_d;
         dmac_q    <= dmac_d;
         smac_q    <= smac_d;
         type_q    <= type_d;
         mask_q    <= mask_d;
      end
   end

   // Read value for the addressed register
   always_comb begin
      rdata_o = EMPTY_WORD;
      case (reg_i)
         REG_INT:   rdata_o = empty_int_i ? EMPTY_WORD : dout_int_i;
         REG_LEN:   rdata_o = empty_len_i ? EMPTY_WORD : {16'h0, dout_len_i};
         REG_CNT:   rdata_o = 32'(cnt_q);
         REG_START: rdata_o = {31'h0, start_q};
         REG_FEN:   rdata_o = {28'h0, fen_q};
         REG_DMAC:  rdata_o = 32'(dmac_q);
         REG_SMAC:  rdata_o = 32'(smac_q);
         REG_TYPE:  rdata_o = 32'(type_q);
         REG_STAT:  rdata_o = {22'h0, err_ovf_q, err_seq_q, 3'b000,
                               (gs_q == GS_ARMED), full_rd_i, full_wr_i, wait_free_i, 1'b0};
         REG_MASK:  rdata_o = {31'h0, mask_q};
         default:   rdata_o = EMPTY_WORD;
      endcase
   end

   assign rden_int_o    = pop_int_q;
   assign rden_len_o    = pop_len_q;
   assign wren_wr_o     = wren_wr_q;
   assign din_wr_o      = din_wr_q;
   assign wren_rd_o     = wren_rd_q;
   assign din_rd_o      = din_rd_q;
   assign start_en_o    = start_q;
   assign filter_en_o   = fen_q[0];
   assign filter_sel_o  = fen_q[3:1];
   assign filter_dmac_o = dmac_q;
   assign filter_smac_o = smac_q;
   assign filter_type_o = type_q;
   assign pend_o        = !empty_int_i && mask_q;

endmodule

// File: rtl/dma_peri_mc.sv
// Multi-channel DMA peripheral front end: address decode, per-channel
// strobes, registered read data / ack, and the IRQ reduction.
module dma_peri_mc
   import dma_peri_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 8,
   parameter int FILTER_W  = 8,
   parameter int GUARD_TMO = 1024
)(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_peri_rden,
   input  logic                       i_peri_wren,
   input  logic [31:0]                i_peri_addr,
   input  logic [31:0]                i_peri_wdata,
   output logic [31:0]                o_peri_rdata,
   output logic                       o_peri_ready,
   output logic                       o_peri_int,
   output logic [NUM_CH-1:0]          o_rden_int,
   input  logic [32*NUM_CH-1:0]       i_dout_int,
   input  logic [NUM_CH-1:0]          i_empty_int,
   output logic [NUM_CH-1:0]          o_rden_length,
   input  logic [16*NUM_CH-1:0]       i_dout_length,
   input  logic [NUM_CH-1:0]          i_empty_length,
   output logic [NUM_CH-1:0]          o_wren_pBufWR,
   output logic [48*NUM_CH-1:0]       o_din_pBufWR,
   input  logic [NUM_CH-1:0]          i_full_pBufWR,
   output logic [NUM_CH-1:0]          o_wren_pBufRD,
   output logic [64*NUM_CH-1:0]       o_din_pBufRD,
   input  logic [NUM_CH-1:0]          i_full_pBufRD,
   input  logic [NUM_CH-1:0]          i_wait_free_pBufWR,
   output logic [NUM_CH-1:0]          o_start_en,
   output logic [NUM_CH-1:0]          o_filter_en,
   output logic [3*NUM_CH-1:0]        o_filter_sel,
   output logic [FILTER_W*NUM_CH-1:0] o_filter_dmac,
   output logic [FILTER_W*NUM_CH-1:0] o_filter_smac,
   output logic [FILTER_W*NUM_CH-1:0] o_filter_type
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CH_W-1:0]               ch_sel;
   logic [3:0]                    reg_sel;
   logic                          ch_ok;
   logic [NUM_CH-1:0][31:0]       ch_rdata;
   logic [NUM_CH-1:0]             pend;
   logic [31:0]                   rd_val;
   logic [31:0]                   rdata_q;
   logic                          ready_q;
   logic                          unused_addr;

   assign ch_sel      = i_peri_addr[6 +: CH_W];
   assign reg_sel     = i_peri_addr[5:2];
   assign unused_addr = ^{i_peri_addr[31:6+CH_W], i_peri_addr[1:0]};

   // Only non power-of-two channel counts leave unmapped channel windows
   if (NUM_CH == (2 ** CH_W)) begin : g_ch_full
      assign ch_ok = 1'b1;
   end else begin : g_ch_part
      assign ch_ok = (ch_sel < CH_W'(NUM_CH));
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic hit;
      assign hit = ch_ok && (ch_sel == CH_W'(g));

      dma_peri_chan #(
         .CNT_W    (CNT_W),
         .FILTER_W (FILTER_W),
         .GUARD_TMO(GUARD_TMO)
      ) u_chan (
         .clk_i        (i_clk),
         .rst_n_i      (i_rst_n),
         .rd_i         (i_peri_rden && hit),
         .wr_i         (i_peri_wren && hit),
         .reg_i        (reg_sel),
         .wdata_i      (i_peri_wdata),
         .dout_int_i   (i_dout_int[32*g +: 32]),
         .empty_int_i  (i_empty_int[g]),
         .dout_len_i   (i_dout_length[16*g +: 16]),
         .empty_len_i  (i_empty_length[g]),
         .full_wr_i    (i_full_pBufWR[g]),
         .full_rd_i    (i_full_pBufRD[g]),
         .wait_free_i  (i_wait_free_pBufWR[g]),
         .rdata_o      (ch_rdata[g]),
         .rden_int_o   (o_rden_int[g]),
         .rden_len_o   (o_rden_length[g]),
         .wren_wr_o    (o_wren_pBufWR[g]),
         .din_wr_o     (o_din_pBufWR[48*g +: 48]),
         .wren_rd_o    (o_wren_pBufRD[g]),
         .din_rd_o     (o_din_pBufRD[64*g +: 64]),
         .start_en_o   (o_start_en[g]),
         .filter_en_o  (o_filter_en[g]),
         .filter_sel_o (o_filter_sel[3*g +: 3]),
         .filter_dmac_o(o_filter_dmac[FILTER_W*g +: FILTER_W]),
         .filter_smac_o(o_filter_smac[FILTER_W*g +: FILTER_W]),
         .filter_type_o(o_filter_type[FILTER_W*g +: FILTER_W]),
         .pend_o       (pend[g])
      );
   end

   // Read mux: unmapped channel, global pending vector, or channel register
   always_comb begin
      rd_val = EMPTY_WORD;
      if (ch_ok) begin
         if (reg_sel == REG_PEND) rd_val = 32'(pend);
         else                     rd_val = ch_rdata[ch_sel];
      end
   end

   // Bus response one cycle after any strobe
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         rdata_q <= i_peri_rden ? rd_val : '0;
         ready_q <= i_peri_rden || i_peri_wren;
      end
   end

   assign o_peri_rdata = rdata_q;
   assign o_peri_ready = ready_q;
   assign o_peri_int   = |pend;

endmodule

// File: tb/tb_dma_peri_mc.sv
// Directed bench for dma_peri_mc with hand-computed expectations.
module tb_dma_peri_mc;

   localparam int NUM_CH = 4;
   localparam int FW     = 8;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n = 1'b0;
   logic                 i_peri_rden = 1'b0, i_peri_wren = 1'b0;
   logic [31:0]          i_peri_addr = '0, i_peri_wdata = '0;
   logic [31:0]          o_peri_rdata;
   logic                 o_peri_ready, o_peri_int;
   logic [NUM_CH-1:0]    o_rden_int, o_rden_length, o_wren_pBufWR, o_wren_pBufRD;
   logic [32*NUM_CH-1:0] i_dout_int = '0;
   logic [NUM_CH-1:0]    i_empty_int = '1, i_empty_length = '1;
   logic [16*NUM_CH-1:0] i_dout_length = '0;
   logic [48*NUM_CH-1:0] o_din_pBufWR;
   logic [64*NUM_CH-1:0] o_din_pBufRD;
   logic [NUM_CH-1:0]    i_full_pBufWR = '0, i_full_pBufRD = '0, i_wait_free_pBufWR = '0;
   logic [NUM_CH-1:0]    o_start_en, o_filter_en;
   logic [3*NUM_CH-1:0]  o_filter_sel;
   logic [FW*NUM_CH-1:0] o_filter_dmac, o_filter_smac, o_filter_type;

   int n_vec = 0;
   int n_err = 0;

   dma_peri_mc #(.NUM_CH(NUM_CH), .CNT_W(8), .FILTER_W(FW), .GUARD_TMO(1024)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_peri_rden(i_peri_rden), .i_peri_wren(i_peri_wren),
      .i_peri_addr(i_peri_addr), .i_peri_wdata(i_peri_wdata),
      .o_peri_rdata(o_peri_rdata), .o_peri_ready(o_peri_ready), .o_peri_int(o_peri_int),
      .o_rden_int(o_rden_int), .i_dout_int(i_dout_int), .i_empty_int(i_empty_int),
      .o_rden_length(o_rden_length), .i_dout_length(i_dout_length), .i_empty_length(i_empty_length),
      .o_wren_pBufWR(o_wren_pBufWR), .o_din_pBufWR(o_din_pBufWR), .i_full_pBufWR(i_full_pBufWR),
      .o_wren_pBufRD(o_wren_pBufRD), .o_din_pBufRD(o_din_pBufRD), .i_full_pBufRD(i_full_pBufRD),
      .i_wait_free_pBufWR(i_wait_free_pBufWR), .o_start_en(o_start_en),
      .o_filter_en(o_filter_en), .o_filter_sel(o_filter_sel),
      .o_filter_dmac(o_filter_dmac), .o_filter_smac(o_filter_smac), .o_filter_type(o_filter_type)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle bus write; returns just after the sampling edge
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge i_clk);
      i_peri_addr = a; i_peri_wdata = d; i_peri_wren = 1'b1;
      @(posedge i_clk); #1;
      i_peri_wren = 1'b0;
   endtask

   // One-cycle bus read; returns just after the sampling edge
   task automatic bus_rd(input logic [31:0] a);
      @(negedge i_clk);
      i_peri_addr = a; i_peri_rden = 1'b1;
      @(posedge i_clk); #1;
      i_peri_rden = 1'b0;
   endtask

   task automatic next_cyc();
      @(posedge i_clk); #1;
   endtask

   initial begin
      // Reset state
      #22;
      chk("rst_ready", 64'(o_peri_ready), 64'h0);
      chk("rst_start", 64'(o_start_en), 64'h0);
      chk("rst_int", 64'(o_peri_int), 64'h0);
      @(negedge i_clk); i_rst_n = 1'b1;

      // 1: ch1 INT pop and packet counter
      i_dout_int[63:32] = 32'h8000_0042; i_empty_int[1] = 1'b0;
      bus_rd(32'h40);
      chk("int_rdata", 64'(o_peri_rdata), 64'h8000_0042);
      chk("int_pop", 64'(o_rden_int), 64'h2);
      chk("int_ready", 64'(o_peri_ready), 64'h1);
      next_cyc();
      chk("int_pop_1cyc", 64'(o_rden_int), 64'h0);
      chk("ready_1cyc", 64'(o_peri_ready), 64'h0);
      i_empty_int[1] = 1'b1;
      bus_rd(32'h58);
      chk("cnt1_inc", 64'(o_peri_rdata), 64'h1);
      bus_rd(32'h40);
      chk("int_empty_rd", 64'(o_peri_rdata), 64'h8000_0000);
      chk("int_empty_nopop", 64'(o_rden_int), 64'h0);
      bus_rd(32'h3C);
      chk("undef_reg", 64'(o_peri_rdata), 64'h8000_0000);

      // 2: ch0 write-descriptor pairing and sequence error
      bus_wr(32'h08, 32'h1000_0000);
      bus_wr(32'h0C, 32'h0000_05EE);
      chk("wr_push", 64'(o_wren_pBufWR), 64'h1);
      chk("wr_din", 64'(o_din_pBufWR[47:0]), 64'h05EE_1000_0000);
      next_cyc();
      chk("wr_push_1cyc", 64'(o_wren_pBufWR), 64'h0);
      bus_wr(32'h0C, 32'h0000_0005);
      chk("wr_seq_nopush", 64'(o_wren_pBufWR), 64'h0);
      bus_rd(32'h30);
      chk("stat0_seq", 64'(o_peri_rdata), 64'h100);
      bus_wr(32'h30, 32'h100);
      bus_rd(32'h30);
      chk("stat0_clr", 64'(o_peri_rdata), 64'h0);

      // 3: ch2 read-descriptor overflow then retry
      i_full_pBufRD[2] = 1'b1;
      bus_wr(32'h90, 32'hAAAA_0001);
      bus_wr(32'h94, 32'hBBBB_0002);
      chk("rd_full_nopush", 64'(o_wren_pBufRD), 64'h0);
      bus_rd(32'hB0);
      chk("stat2_ovf", 64'(o_peri_rdata), 64'h208);
      i_full_pBufRD[2] = 1'b0;
      bus_wr(32'h90, 32'hAAAA_0001);
      bus_wr(32'h94, 32'hBBBB_0002);
      chk("rd_push", 64'(o_wren_pBufRD), 64'h4);

      // 4: ch3 start guard
      bus_wr(32'hDC, 32'h1);
      chk("start_locked", 64'(o_start_en), 64'h0);
      bus_wr(32'hDC, 32'h1234);
      bus_rd(32'hF0);
      chk("stat3_armed", 64'(o_peri_rdata), 64'h10);
      bus_wr(32'hDC, 32'h1);
      chk("start_set", 64'(o_start_en), 64'h8);
      bus_wr(32'hDC, 32'h1234);
      repeat (1100) @(posedge i_clk);
      bus_wr(32'hDC, 32'h0);
      chk("start_tmo", 64'(o_start_en), 64'h8);
      bus_wr(32'hDC, 32'h1234);
      bus_wr(32'hE4, 32'h0);
      bus_wr(32'hDC, 32'h0);
      chk("start_relock", 64'(o_start_en), 64'h8);

      // Filter registers on ch1
      bus_wr(32'h60, 32'hF);
      bus_wr(32'h64, 32'hAB);
      chk("fen1", 64'(o_filter_en), 64'h2);
      chk("fsel1", 64'(o_filter_sel[5:3]), 64'h7);
      chk("dmac1", 64'(o_filter_dmac[15:8]), 64'hAB);

      // 5: counter saturation and CPU write
      bus_wr(32'h18, 32'hFF);
      i_dout_int[31:0] = 32'h8000_0001; i_empty_int[0] = 1'b0;
      bus_rd(32'h00);
      i_empty_int[0] = 1'b1;
      bus_rd(32'h18);
      chk("cnt_sat", 64'(o_peri_rdata), 64'hFF);
      bus_wr(32'h18, 32'h5);
      bus_rd(32'h18);
      chk("cnt_wr", 64'(o_peri_rdata), 64'h5);

      // 6: masked IRQ, pending vector, async reset
      bus_wr(32'hB4, 32'h1);
      i_empty_int = 4'b1010; #1;
      chk("irq_on", 64'(o_peri_int), 64'h1);
      bus_rd(32'h38);
      chk("pend", 64'(o_peri_rdata), 64'h4);
      i_empty_int = 4'b1110; #1;
      chk("irq_masked", 64'(o_peri_int), 64'h0);
      i_empty_int = 4'b1010;
      bus_wr(32'hDC, 32'h1234);
      @(negedge i_clk); i_rst_n = 1'b0; #1;
      chk("arst_start", 64'(o_start_en), 64'h0);
      chk("arst_fen", 64'(o_filter_en), 64'h0);
      chk("arst_int", 64'(o_peri_int), 64'h0);
      @(negedge i_clk); i_rst_n = 1'b1;
      i_empty_int = '1;
      bus_rd(32'hF0);
      chk("arst_locked", 64'(o_peri_rdata), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
